// File: rtl/proc_ctrl_seq_if.sv
// ----------------------------------------------------------------------------
// proc_ctrl_seq_if
// Purpose : Bundles the instruction/status inputs and the datapath strobes that
//           pass between the control sequencer and the processor datapath.
// Modports:
//   slave  - the sequencer: takes run/ir/g_nz/mem_ack, drives every strobe
//   master - the datapath or a bench: drives run/ir/g_nz/mem_ack, sees strobes
// Signals :
//   run      start fetch when the sequencer is in T0
//   ir       {opcode[2:0], rx[RSEL_W-1:0], ry[RSEL_W-1:0]}
//   g_nz     G register non-zero flag
//   mem_ack  memory completes the current ld/st this cycle
//   r_out    one-hot register-to-bus enable
//   r_in     one-hot bus-to-register load
//   g_out, din_out, a_in, g_in, ir_in, addr_in, dout_in  single strobes
//   alu_op   00 add, 01 sub, 10 and
//   mem_req, mem_we  memory request and write qualifier
//   step     one-hot {T3,T2,T1,T0}
//   done     instruction retired pulse
//   err      memory timeout abort pulse (coincides with done)
// ----------------------------------------------------------------------------
interface proc_ctrl_seq_if #(
    parameter int unsigned RSEL_W = 3
) ();
    localparam int unsigned NREGS = 2 ** RSEL_W;
    localparam int unsigned IR_W  = 3 + 2 * RSEL_W;

    logic              run;
    logic [IR_W-1:0]   ir;
    logic              g_nz;
    logic              mem_ack;

    logic [NREGS-1:0]  r_out;
    logic [NREGS-1:0]  r_in;
    logic              g_out;
    logic              din_out;
    logic              a_in;
    logic              g_in;
    logic              ir_in;
    logic [1:0]        alu_op;
    logic              addr_in;
    logic              dout_in;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        step;
    logic              done;
    logic              err;

    modport slave (
        input  run, ir, g_nz, mem_ack,
        output r_out, r_in, g_out, din_out, a_in, g_in, ir_in, alu_op,
               addr_in, dout_in, mem_req, mem_we, step, done, err
    );

    modport master (
        output run, ir, g_nz, mem_ack,
        input  r_out, r_in, g_out, din_out, a_in, g_in, ir_in, alu_op,
               addr_in, dout_in, mem_req, mem_we, step, done, err
    );
endinterface

// File: rtl/proc_ctrl_seq.sv
// ----------------------------------------------------------------------------
// proc_ctrl_seq
// Purpose : Control sequencer for the bus-based processor. Owns the step
//           counter (T0..T3) and a memory wait counter, decodes the 8-opcode
//           set (mv, mvi, add, sub, and, ld, st, mvnz) and drives one-hot
//           register/bus strobes, the ALU op select and the memory handshake.
// Ports   :
//   i_clk    clock, all state on rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      proc_ctrl_seq_if.slave (ir/run/g_nz/mem_ack in, strobes out)
// Params  :
//   RSEL_W   register-select width, NREGS = 2**RSEL_W
//   WAIT_MAX cycles a ld/st may wait for mem_ack before it is aborted (>=1)
// ----------------------------------------------------------------------------
module proc_ctrl_seq #(
    parameter int unsigned RSEL_W   = 3,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    proc_ctrl_seq_if.slave     bus
);
    localparam int unsigned NREGS = 2 ** RSEL_W;
    localparam int unsigned IR_W  = 3 + 2 * RSEL_W;
    // Counter only needs to reach WAIT_MAX-1.
    localparam int unsigned CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);
    localparam logic [NREGS-1:0] ONE_HOT0 = NREGS'(1);

    localparam logic [1:0] ST_T0 = 2'd0;
    localparam logic [1:0] ST_T1 = 2'd1;
    localparam logic [1:0] ST_T2 = 2'd2;
    localparam logic [1:0] ST_T3 = 2'd3;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0] w_wcnt_nxt;

    logic [2:0]        w_op;
    logic [RSEL_W-1:0] w_rx;
    logic [RSEL_W-1:0] w_ry;
    logic [NREGS-1:0]  w_x_oh;
    logic [NREGS-1:0]  w_y_oh;

    logic [NREGS-1:0]  w_r_out;
    logic [NREGS-1:0]  w_r_in;
    logic              w_g_out;
    logic              w_din_out;
    logic              w_a_in;
    logic              w_g_in;
    logic              w_ir_in;
    logic [1:0]        w_alu_op;
    logic              w_addr_in;
    logic              w_dout_in;
    logic              w_mem_req;
    logic              w_mem_we;
    logic              w_done;
    logic              w_err;
    logic [3:0]        w_step;

    assign w_op   = bus.ir[IR_W-1 -: 3];
    assign w_rx   = bus.ir[2*RSEL_W-1 -: RSEL_W];
    assign w_ry   = bus.ir[RSEL_W-1:0];
    assign w_x_oh = ONE_HOT0 << w_rx;
    assign w_y_oh = ONE_HOT0 << w_ry;
    assign w_step = 4'b0001 << r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_T0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // Next state and strobe decode. Strobes are Mealy on run/g_nz/mem_ack so
    // that done/err and the ld write-back land in the completing cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_r_out     = '0;
        w_r_in      = '0;
        w_g_out     = 1'b0;
        w_din_out   = 1'b0;
        w_a_in      = 1'b0;
        w_g_in      = 1'b0;
        w_ir_in     = 1'b0;
        w_alu_op    = ALU_ADD;
        w_addr_in   = 1'b0;
        w_dout_in   = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            ST_T0: begin
                if (bus.run) begin
                    w_din_out   = 1'b1;
                    w_ir_in     = 1'b1;
                    w_state_nxt = ST_T1;
                end
            end

            ST_T1: begin
                case (w_op)
                    OP_MV: begin
                        w_r_out     = w_y_oh;
                        w_r_in      = w_x_oh;
                        w_done      = 1'b1;
                        w_state_nxt = ST_T0;
                    end
                    OP_MVI: begin
                        w_din_out   = 1'b1;
                        w_r_in      = w_x_oh;
                        w_done      = 1'b1;
                        w_state_nxt = ST_T0;
                    end
                    OP_MVNZ: begin
                        if (bus.g_nz) begin
                            w_r_out = w_y_oh;
                            w_r_in  = w_x_oh;
                        end
                        w_done      = 1'b1;
                        w_state_nxt = ST_T0;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        w_r_out     = w_x_oh;
                        w_a_in      = 1'b1;
                        w_state_nxt = ST_T2;
                    end
                    OP_LD, OP_ST: begin
                        w_r_out     = w_y_oh;
                        w_addr_in   = 1'b1;
                        w_wcnt_nxt  = '0;
                        w_state_nxt = ST_T2;
                    end
                    default: w_state_nxt = ST_T0;
                endcase
            end

            ST_T2: begin
                case (w_op)
                    OP_ADD, OP_SUB, OP_AND: begin
                        w_r_out     = w_y_oh;
                        w_g_in      = 1'b1;
                        w_alu_op    = (w_op == OP_SUB) ? ALU_SUB :
                                      (w_op == OP_AND) ? ALU_AND : ALU_ADD;
                        w_state_nxt = ST_T3;
                    end
                    OP_LD, OP_ST: begin
                        w_mem_req = 1'b1;
                        w_mem_we  = (w_op == OP_ST);
                        if (w_op == OP_ST) begin
                            // Keep store data on the bus for the whole access.
                            w_r_out   = w_x_oh;
                            w_dout_in = 1'b1;
                        end
                        if (bus.mem_ack) begin
                            // Ack beats a coincident timeout.
                            if (w_op == OP_LD) begin
                                w_din_out = 1'b1;
                                w_r_in    = w_x_oh;
                            end
                            w_done      = 1'b1;
                            w_wcnt_nxt  = '0;
                            w_state_nxt = ST_T0;
                        end else if (r_wcnt == CNT_LAST) begin
                            w_done      = 1'b1;
                            w_err       = 1'b1;
                            w_wcnt_nxt  = '0;
                            w_state_nxt = ST_T0;
                        end else begin
                            w_wcnt_nxt = r_wcnt + CNT_W'(1);
                        end
                    end
                    default: w_state_nxt = ST_T0;
                endcase
            end

            ST_T3: begin
                w_g_out     = 1'b1;
                w_r_in      = w_x_oh;
                w_done      = 1'b1;
                w_state_nxt = ST_T0;
            end

            default: w_state_nxt = ST_T0;
        endcase
    end

    // Outputs are held quiet for the whole reset window, not just at the edge.
    assign bus.r_out   = i_rst_n ? w_r_out   : '0;
    assign bus.r_in    = i_rst_n ? w_r_in    : '0;
    assign bus.g_out   = i_rst_n & w_g_out;
    assign bus.din_out = i_rst_n & w_din_out;
    assign bus.a_in    = i_rst_n & w_a_in;
    assign bus.g_in    = i_rst_n & w_g_in;
    assign bus.ir_in   = i_rst_n & w_ir_in;
    assign bus.alu_op  = i_rst_n ? w_alu_op  : 2'b00;
    assign bus.addr_in = i_rst_n & w_addr_in;
    assign bus.dout_in = i_rst_n & w_dout_in;
    assign bus.mem_req = i_rst_n & w_mem_req;
    assign bus.mem_we  = i_rst_n & w_mem_we;
    assign bus.done    = i_rst_n & w_done;
    assign bus.err     = i_rst_n & w_err;
    assign bus.step    = i_rst_n ? w_step    : 4'b0001;
endmodule

// File: tb/tb_proc_ctrl_seq.sv
// ----------------------------------------------------------------------------
// tb_proc_ctrl_seq
// Directed bench for proc_ctrl_seq with RSEL_W=3, WAIT_MAX=15. Observed vector
// is {step, r_out, r_in, g_out, din_out, a_in, g_in, ir_in, alu_op, addr_in,
// dout_in, mem_req, mem_we, done, err}.
// ----------------------------------------------------------------------------
module tb_proc_ctrl_seq;
    localparam logic [2:0] MV = 3'b000, MVI = 3'b001, ADD = 3'b010, SUB = 3'b011;
    localparam logic [2:0] LD = 3'b100, ST = 3'b101, MVNZ = 3'b110, AND = 3'b111;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [32:0] exp_v;

    proc_ctrl_seq_if #(.RSEL_W(3)) bus ();

    proc_ctrl_seq #(.RSEL_W(3), .WAIT_MAX(15)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    wire [32:0] obs = {bus.step, bus.r_out, bus.r_in, bus.g_out, bus.din_out, bus.a_in,
                       bus.g_in, bus.ir_in, bus.alu_op, bus.addr_in, bus.dout_in,
                       bus.mem_req, bus.mem_we, bus.done, bus.err};

    // f5 = {g_out,din_out,a_in,g_in,ir_in}; f6 = {addr_in,dout_in,mem_req,mem_we,done,err}
    function automatic logic [32:0] pk(logic [3:0] st, logic [7:0] ro, logic [7:0] ri,
                                       logic [4:0] f5, logic [1:0] op, logic [5:0] f6);
        return {st, ro, ri, f5, op, f6};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus driver and destination-load invariants, every active cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp = n_cmp + 1;
            if ($countones({bus.r_out, bus.g_out, bus.din_out}) > 1 ||
                $countones(bus.r_in) > 1) begin
                n_err = n_err + 1;
                $display("FAIL bus_onehot @%0t: got drivers=%b r_in=%b want <=1 each", $time,
                         {bus.r_out, bus.g_out, bus.din_out}, bus.r_in);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        run_in(1'b1);
        samp();
        exp_v = pk(4'b0001, 8'h00, 8'h00, 5'b00000, 2'b00, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL rst_hold: got %h want %h", obs, exp_v); end
        adv();
        rst_n = 1'b1;
        run_in(1'b0);
        for (int i = 0; i < 2; i++) begin
            samp();
            n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL rst_idle: got %h want %h", obs, exp_v); end
            adv();
        end
        // Reset in the middle of an add.
        bus.ir = {ADD, 3'd2, 3'd3};
        run_in(1'b1);
        samp();
        exp_v = pk(4'b0001, 8'h00, 8'h00, 5'b01001, 2'b00, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL add_t0: got %h want %h", obs, exp_v); end
        adv();
        run_in(1'b0);
        samp();
        exp_v = pk(4'b0010, 8'h04, 8'h00, 5'b00100, 2'b00, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL add_t1: got %h want %h", obs, exp_v); end
        adv();
        samp();
        exp_v = pk(4'b0100, 8'h08, 8'h00, 5'b00010, 2'b00, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL add_t2: got %h want %h", obs, exp_v); end
        #1 rst_n = 1'b0;
        #1;
        exp_v = pk(4'b0001, 8'h00, 8'h00, 5'b00000, 2'b00, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL rst_mid: got %h want %h", obs, exp_v); end
        adv();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            samp();
            n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL rst_after: got %h want %h", obs, exp_v); end
            adv();
        end
    endtask

    task automatic run_in(input logic v);
        bus.run = v;
    endtask

    task automatic fetch(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
        bus.ir  = {op, x, y};
        bus.run = 1'b1;
        adv();
        bus.run = 1'b0;
    endtask

    task automatic test_mvi();
        bus.ir  = {MVI, 3'd3, 3'd0};
        bus.run = 1'b1;
        samp();
        exp_v = pk(4'b0001, 8'h00, 8'h00, 5'b01001, 2'b00, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL mvi_t0: got %h want %h", obs, exp_v); end
        adv();
        bus.run = 1'b0;
        samp();
        exp_v = pk(4'b0010, 8'h00, 8'h08, 5'b01000, 2'b00, 6'b000010);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL mvi_t1: got %h want %h", obs, exp_v); end
        adv();
        samp();
        exp_v = pk(4'b0001, 8'h00, 8'h00, 5'b00000, 2'b00, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL mvi_after: got %h want %h", obs, exp_v); end
        adv();
    endtask

    task automatic test_sub();
        fetch(SUB, 3'd1, 3'd5);
        bus.run = 1'b1; // ignored outside T0
        samp();
        exp_v = pk(4'b0010, 8'h02, 8'h00, 5'b00100, 2'b00, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL sub_t1: got %h want %h", obs, exp_v); end
        adv();
        samp();
        exp_v = pk(4'b0100, 8'h20, 8'h00, 5'b00010, 2'b01, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL sub_t2: got %h want %h", obs, exp_v); end
        adv();
        samp();
        exp_v = pk(4'b1000, 8'h00, 8'h02, 5'b10000, 2'b00, 6'b000010);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL sub_t3: got %h want %h", obs, exp_v); end
        adv();
        bus.run = 1'b0;
        samp();
        exp_v = pk(4'b0001, 8'h00, 8'h00, 5'b00000, 2'b00, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL sub_after: got %h want %h", obs, exp_v); end
        adv();
    endtask

    task automatic test_and_same_reg();
        fetch(AND, 3'd6, 3'd6);
        samp();
        exp_v = pk(4'b0010, 8'h40, 8'h00, 5'b00100, 2'b00, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL and_t1: got %h want %h", obs, exp_v); end
        adv();
        samp();
        exp_v = pk(4'b0100, 8'h40, 8'h00, 5'b00010, 2'b10, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL and_t2: got %h want %h", obs, exp_v); end
        adv();
        samp();
        exp_v = pk(4'b1000, 8'h00, 8'h40, 5'b10000, 2'b00, 6'b000010);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL and_t3: got %h want %h", obs, exp_v); end
        adv();
    endtask

    task automatic test_mv();
        fetch(MV, 3'd5, 3'd2);
        samp();
        exp_v = pk(4'b0010, 8'h04, 8'h20, 5'b00000, 2'b00, 6'b000010);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL mv_t1: got %h want %h", obs, exp_v); end
        adv();
    endtask

    task automatic test_mvnz();
        bus.g_nz = 1'b0;
        fetch(MVNZ, 3'd0, 3'd7);
        samp();
        exp_v = pk(4'b0010, 8'h00, 8'h00, 5'b00000, 2'b00, 6'b000010);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL mvnz_z: got %h want %h", obs, exp_v); end
        adv();
        fetch(MVNZ, 3'd0, 3'd7);
        bus.g_nz = 1'b1;
        samp();
        exp_v = pk(4'b0010, 8'h80, 8'h01, 5'b00000, 2'b00, 6'b000010);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL mvnz_nz: got %h want %h", obs, exp_v); end
        adv();
        bus.g_nz = 1'b0;
    endtask

    task automatic test_ld();
        int reqs;
        reqs = 0;
        fetch(LD, 3'd4, 3'd6);
        bus.mem_ack = 1'b1; // ignored outside T2
        samp();
        exp_v = pk(4'b0010, 8'h40, 8'h00, 5'b00000, 2'b00, 6'b100000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL ld_t1: got %h want %h", obs, exp_v); end
        adv();
        for (int c = 0; c < 4; c++) begin
            bus.mem_ack = (c == 3);
            samp();
            if (bus.mem_req) reqs++;
            exp_v = (c < 3) ? pk(4'b0100, 8'h00, 8'h00, 5'b00000, 2'b00, 6'b001000)
                            : pk(4'b0100, 8'h00, 8'h10, 5'b01000, 2'b00, 6'b001010);
            n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL ld_t2_%0d: got %h want %h", c, obs, exp_v); end
            adv();
        end
        bus.mem_ack = 1'b0;
        samp();
        exp_v = pk(4'b0001, 8'h00, 8'h00, 5'b00000, 2'b00, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL ld_after: got %h want %h", obs, exp_v); end
        n_cmp++; if (reqs !== 4) begin n_err++; $display("FAIL ld_req_cycles: got %0d want 4", reqs); end
        adv();
    endtask

    task automatic test_st_timeout();
        int reqs;
        reqs = 0;
        fetch(ST, 3'd3, 3'd1);
        samp();
        exp_v = pk(4'b0010, 8'h02, 8'h00, 5'b00000, 2'b00, 6'b100000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL st_t1: got %h want %h", obs, exp_v); end
        adv();
        for (int c = 0; c < 15; c++) begin
            samp();
            if (bus.mem_req && bus.mem_we) reqs++;
            exp_v = (c < 14) ? pk(4'b0100, 8'h08, 8'h00, 5'b00000, 2'b00, 6'b011100)
                             : pk(4'b0100, 8'h08, 8'h00, 5'b00000, 2'b00, 6'b011111);
            n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL st_to_%0d: got %h want %h", c, obs, exp_v); end
            adv();
        end
        samp();
        exp_v = pk(4'b0001, 8'h00, 8'h00, 5'b00000, 2'b00, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL st_to_after: got %h want %h", obs, exp_v); end
        n_cmp++; if (reqs !== 15) begin n_err++; $display("FAIL st_req_cycles: got %0d want 15", reqs); end
        adv();
    endtask

    // Random ack latency; the last access acks in the timeout cycle itself.
    task automatic test_mem_random();
        for (int k = 0; k < 6; k++) begin
            logic [2:0] op;
            logic [2:0] x;
            logic [2:0] y;
            logic [7:0] xoh;
            logic [7:0] yoh;
            int w;
            op  = k[0] ? ST : LD;
            x   = 3'(k + 1);
            y   = 3'(6 - k);
            xoh = 8'h01 << x;
            yoh = 8'h01 << y;
            w   = (k == 5) ? 14 : int'($urandom_range(0, 13));
            fetch(op, x, y);
            samp();
            exp_v = pk(4'b0010, yoh, 8'h00, 5'b00000, 2'b00, 6'b100000);
            n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL rnd%0d_t1: got %h want %h", k, obs, exp_v); end
            adv();
            for (int c = 0; c <= w; c++) begin
                bus.mem_ack = (c == w);
                samp();
                if (op == LD)
                    exp_v = (c < w) ? pk(4'b0100, 8'h00, 8'h00, 5'b00000, 2'b00, 6'b001000)
                                    : pk(4'b0100, 8'h00, xoh, 5'b01000, 2'b00, 6'b001010);
                else
                    exp_v = (c < w) ? pk(4'b0100, xoh, 8'h00, 5'b00000, 2'b00, 6'b011100)
                                    : pk(4'b0100, xoh, 8'h00, 5'b00000, 2'b00, 6'b011110);
                n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL rnd%0d_w%0d_c%0d: got %h want %h", k, w, c, obs, exp_v); end
                adv();
            end
            bus.mem_ack = 1'b0;
            samp();
            n_cmp++; if (bus.step !== 4'b0001) begin n_err++; $display("FAIL rnd%0d_after: got step %b want 0001", k, bus.step); end
            adv();
        end
    endtask

    task automatic test_back_to_back();
        bus.run = 1'b1;
        bus.ir  = {MVI, 3'd1, 3'd0};
        samp();
        exp_v = pk(4'b0001, 8'h00, 8'h00, 5'b01001, 2'b00, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL b2b_f0: got %h want %h", obs, exp_v); end
        adv();
        samp();
        exp_v = pk(4'b0010, 8'h00, 8'h02, 5'b01000, 2'b00, 6'b000010);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL b2b_mvi: got %h want %h", obs, exp_v); end
        adv();
        bus.ir = {MV, 3'd2, 3'd1};
        samp();
        exp_v = pk(4'b0001, 8'h00, 8'h00, 5'b01001, 2'b00, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL b2b_f1: got %h want %h", obs, exp_v); end
        adv();
        samp();
        exp_v = pk(4'b0010, 8'h02, 8'h04, 5'b00000, 2'b00, 6'b000010);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL b2b_mv: got %h want %h", obs, exp_v); end
        adv();
        bus.ir = {ADD, 3'd2, 3'd2};
        adv();
        samp();
        exp_v = pk(4'b0010, 8'h04, 8'h00, 5'b00100, 2'b00, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL b2b_add_t1: got %h want %h", obs, exp_v); end
        adv();
        samp();
        exp_v = pk(4'b0100, 8'h04, 8'h00, 5'b00010, 2'b00, 6'b000000);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL b2b_add_t2: got %h want %h", obs, exp_v); end
        adv();
        samp();
        exp_v = pk(4'b1000, 8'h00, 8'h04, 5'b10000, 2'b00, 6'b000010);
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL b2b_add_t3: got %h want %h", obs, exp_v); end
        adv();
        bus.run = 1'b0;
        samp();
        n_cmp++; if (bus.step !== 4'b0001) begin n_err++; $display("FAIL b2b_after: got step %b want 0001", bus.step); end
        adv();
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        bus.run     = 1'b0;
        bus.ir      = '0;
        bus.g_nz    = 1'b0;
        bus.mem_ack = 1'b0;
        #1;
        test_reset();
        test_mvi();
        test_sub();
        test_and_same_reg();
        test_mv();
        test_mvnz();
        test_ld();
        test_st_timeout();
        test_mem_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
